// File: rtl/keccak_dec_pkg.sv
// Shared types and row functions for the Keccak decoder datapath.
// A slice is 5 rows of 5 bits, bit index = 5*y + x.
package keccak_dec_pkg;

  typedef logic [24:0] slice_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int NUM_SLICES = 64;
  localparam int ROWS       = 5;
  localparam int ROW_W      = 5;

  // Forward chi on one row: a'[x] = a[x] ^ (~a[x+1] & a[x+2]), indices mod 5.
  // The two concatenations are the row rotated right by one and by two.
  function automatic logic [4:0] chi_row(input logic [4:0] a);
    return a ^ (~{a[0], a[4:1]} & {a[1:0], a[4:2]});
  endfunction

  // Inverse chi on one row. Chi is a bijection on 5 bits, so searching all
  // 32 candidates finds exactly one preimage; the argument-independent loop
  // folds into a constant 32-entry table.
  function automatic logic [4:0] inv_chi_row(input logic [4:0] a);
    logic [4:0] r;
    r = '0;
    for (int v = 0; v < 32; v++) begin
      if (chi_row(v[4:0]) == a) r = v[4:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/inv_revaluate_if.sv
// Start/done handshake and state bus of the inverse-chi stage.
// Optional macro INV_REVALUATE_SELFCHECK_EN adds the sticky chk_err flag.
interface inv_revaluate_if;
  import keccak_dec_pkg::*;

  logic   start;
  slice_t in  [0:NUM_SLICES-1];
  slice_t out [0:NUM_SLICES-1];
  logic   done;
  logic   busy;
`ifdef INV_REVALUATE_SELFCHECK_EN
  logic   chk_err;

  modport master (output start, output in, input out, input done, input busy, input chk_err);
  modport slave  (input start, input in, output out, output done, output busy, output chk_err);
`else
  modport master (output start, output in, input out, input done, input busy);
  modport slave  (input start, input in, output out, output done, output busy);
`endif

endinterface

// File: rtl/inv_chi_slice.sv
// Combinational inverse chi of one 25-bit slice: five independent rows.
module inv_chi_slice
  import keccak_dec_pkg::*;
(
  input  slice_t src,
  output slice_t res
);

  for (genvar y = 0; y < ROWS; y++) begin : g_row
    assign res[ROW_W*y +: ROW_W] = inv_chi_row(src[ROW_W*y +: ROW_W]);
  end

endmodule

// File: rtl/inv_revaluate.sv
// Decoder inverse of the chi (revaluate) step over the 64-slice state.
// SLICES_PER_CYCLE slices are inverted per RUN cycle from a buffered copy
// of the input; results land in the registered out array.
// Optional macro INV_REVALUATE_SELFCHECK_EN re-encodes every written row and
// raises a sticky chk_err on any disagreement with its source row.
module inv_revaluate
  import keccak_dec_pkg::*;
#(
  parameter int SLICES_PER_CYCLE = 8
) (
  input  logic           clk,
  input  logic           rst,
  inv_revaluate_if.slave bus
);

  localparam int NUM_GROUPS = NUM_SLICES / SLICES_PER_CYCLE;
  localparam int CNT_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam int IDX_W      = $clog2(NUM_SLICES);
  localparam logic [CNT_W-1:0] LAST_GROUP = CNT_W'(NUM_GROUPS - 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] count;
  logic             load;
  logic             last_group;
  slice_t           hold [NUM_SLICES];
  logic [IDX_W-1:0] idx  [SLICES_PER_CYCLE];
  slice_t           src  [SLICES_PER_CYCLE];
  slice_t           res  [SLICES_PER_CYCLE];

  assign last_group = (count == LAST_GROUP);
  assign bus.done   = (state == DONE);
  assign bus.busy   = (state == RUN);

  // One inverse-chi lane per slice handled in a cycle; count selects the group.
  for (genvar i = 0; i < SLICES_PER_CYCLE; i++) begin : g_lane
    assign idx[i] = IDX_W'(int'(count) * SLICES_PER_CYCLE + i);
    assign src[i] = hold[idx[i]];
    inv_chi_slice u_slice (
      .src (src[i]),
      .res (res[i])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next state: start is only honoured outside RUN, so a running job can't be restarted.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          next_state = RUN;
          load       = 1'b1;
        end
      end
      RUN: begin
        if (last_group) next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: capture the input on the accepting edge, then write one group per RUN cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= '0;
      hold    <= '{default: '0};
      bus.out <= '{default: '0};
    end else if (load) begin
      count <= '0;
      hold  <= bus.in;
    end else if (state == RUN) begin
      for (int i = 0; i < SLICES_PER_CYCLE; i++) begin
        bus.out[idx[i]] <= res[i];
      end
      count <= last_group ? '0 : count + 1'b1;
    end
  end

`ifdef INV_REVALUATE_SELFCHECK_EN
  logic [ROWS-1:0] row_bad [SLICES_PER_CYCLE];

  for (genvar i = 0; i < SLICES_PER_CYCLE; i++) begin : g_chk
    for (genvar y = 0; y < ROWS; y++) begin : g_chk_row
      assign row_bad[i][y] =
        (chi_row(res[i][ROW_W*y +: ROW_W]) != src[i][ROW_W*y +: ROW_W]);
    end
  end

  // Sticky error flag: any written row whose re-encoding differs from its source.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.chk_err <= 1'b0;
    end else if (load) begin
      bus.chk_err <= 1'b0;
    end else if (state == RUN) begin
      for (int i = 0; i < SLICES_PER_CYCLE; i++) begin
        for (int y = 0; y < ROWS; y++) begin
          if (row_bad[i][y]) begin
            bus.chk_err <= 1'b1;
            $error("inv_revaluate: self-check mismatch at slice %0d row %0d", idx[i], y);
          end
        end
      end
    end
  end
`endif

endmodule
